// File: rtl/frame_ingest_pingpong_if.sv
// Bundle of the UART byte input, IFMAP bank write port and consumer handshake
// for the ping-pong frame loader.
interface frame_ingest_pingpong_if #(
  parameter int AW         = 5,
  parameter int DATA_WIDTH = 16,
  parameter int CNT_W      = 8
);
  logic                  rx_dv;
  logic [7:0]            rx_byte;
  logic                  wr_en;
  logic                  wr_bank;
  logic [AW-1:0]         wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  frame_valid;
  logic                  rd_bank;
  logic                  frame_done;
  logic                  loading;
  logic [CNT_W-1:0]      drop_cnt;
  logic [CNT_W-1:0]      timeout_cnt;

  modport master (
    input  rx_dv, rx_byte, frame_done,
    output wr_en, wr_bank, wr_addr, wr_data, frame_valid, rd_bank,
           loading, drop_cnt, timeout_cnt
  );

  modport slave (
    output rx_dv, rx_byte, frame_done,
    input  wr_en, wr_bank, wr_addr, wr_data, frame_valid, rd_bank,
           loading, drop_cnt, timeout_cnt
  );
endinterface

// File: rtl/frame_ingest_pingpong.sv
// Sync-byte framed UART pixel loader writing Q(FRAC_BITS) pixels into two
// IFMAP banks used as a two-entry FIFO, with drop and timeout accounting.
module frame_ingest_pingpong #(
  parameter int          DATA_WIDTH     = 16,
  parameter int          FRAC_BITS      = 7,
  parameter int          IMG_H          = 28,
  parameter int          IMG_W          = 28,
  parameter int          CHANNELS       = 1,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 1_000_000,
  parameter int          CNT_W          = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  frame_ingest_pingpong_if.master  bus
);
  localparam int               FRAME     = CHANNELS * IMG_H * IMG_W;
  localparam int               AW        = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam logic [AW-1:0]    LAST_ADDR = AW'(FRAME - 1);
  localparam logic [31:0]      TIMEOUT   = 32'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  // Rounded k*2^FRAC_BITS/255 for every byte value, fixed at elaboration.
  logic [DATA_WIDTH-1:0] lut_s [256];
  for (genvar k = 0; k < 256; k++) begin : g_lut
    localparam int unsigned VAL = (k * (32'd1 << FRAC_BITS) + 32'd127) / 32'd255;
    assign lut_s[k] = DATA_WIDTH'(VAL);
  end

  logic [1:0]            state_r;
  logic [AW-1:0]         addr_r;
  logic [31:0]           gap_r;
  logic                  wr_ptr_r;
  logic                  rd_ptr_r;
  logic [1:0]            full_r;
  logic                  wr_last_r;
  logic                  wr_en_r;
  logic                  wr_bank_r;
  logic [AW-1:0]         wr_addr_r;
  logic [DATA_WIDTH-1:0] wr_data_r;
  logic                  frame_valid_r;
  logic [CNT_W-1:0]      drop_cnt_r;
  logic [CNT_W-1:0]      timeout_cnt_r;

  logic [1:0] full_nxt_s;
  logic       wr_ptr_nxt_s;
  logic       rd_ptr_nxt_s;
  logic       timeout_s;

  // Bank bookkeeping: completion sets the write bank, frame_done frees the read bank.
  always_comb begin
    full_nxt_s   = full_r;
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    if (wr_en_r && wr_last_r) begin
      full_nxt_s[wr_ptr_r] = 1'b1;
      wr_ptr_nxt_s         = ~wr_ptr_r;
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
    if (bus.frame_done && full_r[rd_ptr_r]) begin
      full_nxt_s[rd_ptr_r] = 1'b0;
      rd_ptr_nxt_s         = ~rd_ptr_r;
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
  end

  // Inter-byte gap limit inside a frame; a zero limit disables it.
  always_comb begin
    timeout_s = 1'b0;
    if ((TIMEOUT != 32'd0) && (state_r != ST_IDLE) && !bus.rx_dv) begin
      timeout_s = ((gap_r + 32'd1) == TIMEOUT);
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Frame FSM, registered write port, gap counter and error counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      addr_r        <= '0;
      gap_r         <= 32'd0;
      wr_ptr_r      <= 1'b0;
      rd_ptr_r      <= 1'b0;
      full_r        <= 2'b00;
      wr_last_r     <= 1'b0;
      wr_en_r       <= 1'b0;
      wr_bank_r     <= 1'b0;
      wr_addr_r     <= '0;
      wr_data_r     <= '0;
      frame_valid_r <= 1'b0;
      drop_cnt_r    <= '0;
      timeout_cnt_r <= '0;
    end else begin
      full_r        <= full_nxt_s;
      wr_ptr_r      <= wr_ptr_nxt_s;
      rd_ptr_r      <= rd_ptr_nxt_s;
      frame_valid_r <= full_nxt_s[rd_ptr_nxt_s];
      wr_en_r       <= 1'b0;
      wr_last_r     <= 1'b0;
      if ((TIMEOUT != 32'd0) && (state_r != ST_IDLE) && !bus.rx_dv) begin
        gap_r <= gap_r + 32'd1;
      end else begin
        gap_r <= 32'd0;
      end

      case (state_r)
        ST_IDLE: begin
          // Decide against the post-completion flags so a sync right after a
          // frame end sees the bank that just filled.
          if (bus.rx_dv && (bus.rx_byte == SYNC_BYTE)) begin
            addr_r  <= '0;
            state_r <= full_nxt_s[wr_ptr_nxt_s] ? ST_DROP : ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (timeout_s) begin
            state_r       <= ST_IDLE;
            addr_r        <= '0;
            gap_r         <= 32'd0;
            timeout_cnt_r <= (timeout_cnt_r == CNT_MAX) ? timeout_cnt_r : timeout_cnt_r + CNT_W'(1);
          end else if (bus.rx_dv) begin
            wr_en_r   <= 1'b1;
            wr_bank_r <= wr_ptr_r;
            wr_addr_r <= addr_r;
            wr_data_r <= lut_s[bus.rx_byte];
            wr_last_r <= (addr_r == LAST_ADDR);
            if (addr_r == LAST_ADDR) begin
              state_r <= ST_IDLE;
              addr_r  <= '0;
            end else begin
              addr_r <= addr_r + AW'(1'b1);
            end
          end
        end
        ST_DROP: begin
          if (timeout_s) begin
            state_r       <= ST_IDLE;
            addr_r        <= '0;
            gap_r         <= 32'd0;
            timeout_cnt_r <= (timeout_cnt_r == CNT_MAX) ? timeout_cnt_r : timeout_cnt_r + CNT_W'(1);
          end else if (bus.rx_dv) begin
            if (addr_r == LAST_ADDR) begin
              state_r    <= ST_IDLE;
              addr_r     <= '0;
              drop_cnt_r <= (drop_cnt_r == CNT_MAX) ? drop_cnt_r : drop_cnt_r + CNT_W'(1);
            end else begin
              addr_r <= addr_r + AW'(1'b1);
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          addr_r  <= '0;
        end
      endcase
    end
  end

  assign bus.wr_en       = wr_en_r;
  assign bus.wr_bank     = wr_bank_r;
  assign bus.wr_addr     = wr_addr_r;
  assign bus.wr_data     = wr_data_r;
  assign bus.frame_valid = frame_valid_r;
  assign bus.rd_bank     = rd_ptr_r;
  assign bus.loading     = (state_r == ST_LOAD);
  assign bus.drop_cnt    = drop_cnt_r;
  assign bus.timeout_cnt = timeout_cnt_r;
endmodule

// File: tb/tb_frame_ingest_pingpong.sv
// Randomised directed bench for frame_ingest_pingpong: a frame-level model
// predicts writes, bank FIFO order and error counters.
module tb_frame_ingest_pingpong;
  localparam int FRAME = 32;
  localparam int AW    = 5;
  localparam int DW    = 16;
  localparam int CW    = 8;

  typedef logic [AW+DW:0] wr_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  frame_ingest_pingpong_if #(.AW(AW), .DATA_WIDTH(DW), .CNT_W(CW)) bus ();

  frame_ingest_pingpong #(
    .DATA_WIDTH(DW), .FRAC_BITS(7), .IMG_H(4), .IMG_W(4), .CHANNELS(2),
    .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(50), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  wr_t        obs_q[$];
  int         obs_base = 0;
  wr_t        exp_q[$];
  logic [7:0] pix [FRAME];
  int         m_full_q[$];
  int         m_wr_ptr, m_rd_ptr, m_drop, m_timeout;

  always @(negedge clk) begin
    if (!reset && bus.wr_en) obs_q.push_back({bus.wr_bank, bus.wr_addr, bus.wr_data});
  end

  function automatic logic [DW-1:0] conv(input logic [7:0] k);
    int v;
    v = (int'(k) * 128 + 127) / 255;
    return DW'(v);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.rx_dv   = 1'b1;
    bus.rx_byte = b;
    @(posedge clk); #1;
    bus.rx_dv = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic fill_pix();
    for (int i = 0; i < FRAME; i++) pix[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic send_pixels(input int n, input int last_gap);
    send_byte(8'hA5, $urandom_range(0, 3));
    for (int i = 0; i < n; i++) send_byte(pix[i], (i == n - 1) ? last_gap : $urandom_range(0, 3));
  endtask

  // mode 0: complete frame, 1: timed out, 2: cut by reset
  task automatic model_frame(input int n, input int mode);
    if (m_full_q.size() == 2) begin
      if (mode == 0 && m_drop < 255) m_drop++;
      if (mode == 1 && m_timeout < 255) m_timeout++;
    end else begin
      for (int i = 0; i < n; i++) exp_q.push_back({m_wr_ptr[0], AW'(i), conv(pix[i])});
      if (mode == 0) begin
        m_full_q.push_back(m_wr_ptr);
        m_wr_ptr ^= 1;
      end else if (mode == 1 && m_timeout < 255) begin
        m_timeout++;
      end
    end
  endtask

  task automatic frame_done_pulse();
    int b;
    bus.frame_done = 1'b1;
    @(posedge clk); #1;
    bus.frame_done = 1'b0;
    if (m_full_q.size() > 0) begin
      b = m_full_q.pop_front();
      m_rd_ptr = b ^ 1;
    end
  endtask

  task automatic check_writes(input string tag);
    wr_t o;
    repeat (2) begin @(posedge clk); #1; end
    chk({tag, "_wr_count"}, obs_q.size() - obs_base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (obs_base + i < obs_q.size()) begin
        o = obs_q[obs_base + i];
        chk({tag, "_wr"}, o, exp_q[i]);
      end
    end
    obs_base = obs_q.size();
    exp_q.delete();
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_frame_valid"}, bus.frame_valid, (m_full_q.size() > 0) ? 1 : 0);
    chk({tag, "_rd_bank"}, bus.rd_bank, (m_full_q.size() > 0) ? m_full_q[0] : m_rd_ptr);
    chk({tag, "_drop_cnt"}, bus.drop_cnt, m_drop);
    chk({tag, "_timeout_cnt"}, bus.timeout_cnt, m_timeout);
    chk({tag, "_loading"}, bus.loading, 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_wr_en"}, bus.wr_en, 0);
    chk({tag, "_wr_bank"}, bus.wr_bank, 0);
    chk({tag, "_wr_addr"}, bus.wr_addr, 0);
    chk({tag, "_wr_data"}, bus.wr_data, 0);
    chk({tag, "_frame_valid"}, bus.frame_valid, 0);
    chk({tag, "_rd_bank"}, bus.rd_bank, 0);
    chk({tag, "_loading"}, bus.loading, 0);
    chk({tag, "_drop_cnt"}, bus.drop_cnt, 0);
    chk({tag, "_timeout_cnt"}, bus.timeout_cnt, 0);
  endtask

  task automatic model_reset();
    m_full_q.delete();
    m_wr_ptr = 0; m_rd_ptr = 0; m_drop = 0; m_timeout = 0;
    exp_q.delete();
    obs_base = obs_q.size();
  endtask

  initial begin
    wr_t o;
    int  b0;
    reset = 1'b1; bus.rx_dv = 1'b0; bus.rx_byte = 8'h00; bus.frame_done = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_zero("reset");

    // garbage before sync is ignored
    send_byte(8'h00, 1); send_byte(8'hFF, 0); send_byte(8'h12, 2);
    check_writes("garbage");
    check_state("garbage");

    // first frame: known conversions, embedded sync value, frame_valid timing
    fill_pix();
    pix[0] = 8'd0; pix[1] = 8'd1; pix[2] = 8'd128; pix[3] = 8'd255; pix[5] = 8'hA5;
    b0 = obs_base;
    send_pixels(FRAME, 0);
    chk("t1_last_wr_en", bus.wr_en, 1);
    chk("t1_last_addr", bus.wr_addr, FRAME - 1);
    chk("t1_fv_not_yet", bus.frame_valid, 0);
    chk("t1_loading_off", bus.loading, 0);
    @(posedge clk); #1;
    chk("t1_fv_rise", bus.frame_valid, 1);
    chk("t1_rd_bank", bus.rd_bank, 0);
    model_frame(FRAME, 0);
    if (obs_q.size() >= b0 + 6) begin
      o = obs_q[b0 + 0]; chk("t1_px0", o[DW-1:0], 0);
      o = obs_q[b0 + 1]; chk("t1_px1", o[DW-1:0], 1);
      o = obs_q[b0 + 2]; chk("t1_px128", o[DW-1:0], 64);
      o = obs_q[b0 + 3]; chk("t1_px255", o[DW-1:0], 128);
      o = obs_q[b0 + 5]; chk("t1_pxA5", o[DW-1:0], 83);
    end else begin
      chk("t1_early_writes", obs_q.size() - b0, 6);
    end
    check_writes("t1");
    check_state("t1");

    // second frame lands on bank 1; frame_done advances to bank 1
    fill_pix(); send_pixels(FRAME, 1); model_frame(FRAME, 0);
    check_writes("t2"); check_state("t2");
    frame_done_pulse(); check_state("t2_done");

    // refill bank 0, then a third frame is dropped
    fill_pix(); send_pixels(FRAME, 1); model_frame(FRAME, 0);
    check_writes("t3_fill"); check_state("t3_fill");
    fill_pix(); send_pixels(FRAME, 1); model_frame(FRAME, 0);
    check_writes("t3_drop"); check_state("t3_drop");
    frame_done_pulse();
    fill_pix(); send_pixels(FRAME, 1); model_frame(FRAME, 0);
    check_writes("t3_after"); check_state("t3_after");

    // timeout while loading, then the same bank refills from address 0
    frame_done_pulse();
    fill_pix(); send_pixels(11, 0);
    chk("t4_loading", bus.loading, 1);
    repeat (60) @(posedge clk); #1;
    model_frame(11, 1);
    check_writes("t4_to"); check_state("t4_to");
    fill_pix(); send_pixels(FRAME, 1); model_frame(FRAME, 0);
    check_writes("t4_refill"); check_state("t4_refill");

    // timeout while dropping
    fill_pix(); send_pixels(5, 0);
    repeat (60) @(posedge clk); #1;
    model_frame(5, 1);
    check_writes("t4_drop_to"); check_state("t4_drop_to");

    // reset in the middle of a frame clears everything
    frame_done_pulse(); frame_done_pulse();
    check_state("t6_empty");
    fill_pix(); send_pixels(20, 0); model_frame(20, 2);
    check_writes("t6_partial");
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    check_zero("t6_reset");

    // frame_done coincident with completion of the other bank
    fill_pix(); send_pixels(FRAME, 1); model_frame(FRAME, 0);
    check_writes("t6_a"); check_state("t6_a");
    fill_pix(); send_pixels(FRAME, 0); model_frame(FRAME, 0);
    frame_done_pulse();
    check_writes("t6_coinc"); check_state("t6_coinc");
    frame_done_pulse(); check_state("t6_last_done");
    frame_done_pulse(); check_state("t6_idle_done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/frame_ingest_pingpong.md
Name: frame_ingest_pingpong

Overview:
Parametrised UART frame loader that replaces the single-buffer pixel loader in front of the CNN pipeline. It waits for a sync byte, then accepts CHANNELS×IMG_H×IMG_W pixel bytes in CHW order. Each byte is converted to signed Q(FRAC_BITS) fixed point and written into one of two IFMAP banks (ping-pong), so the next frame can load while conv2d consumes the current one. It also handles bank-full drops, inter-byte timeouts and error counting.

Parameters:
DATA_WIDTH, 16, pixel word width after conversion
FRAC_BITS, 7, fractional bits of the converted pixel
IMG_H, 28, frame rows
IMG_W, 28, frame columns
CHANNELS, 1, input channels per frame (CHW order on the wire)
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT_CYCLES, 1_000_000, max clk cycles between bytes inside a frame; 0 disables the timeout
CNT_W, 8, width of the saturating error counters
(derived) FRAME = CHANNELS*IMG_H*IMG_W; AW = $clog2(FRAME)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
rx_dv  in  1  one-cycle strobe: rx_byte valid
rx_byte  in  8  received byte
wr_en  out  1  IFMAP bank write strobe
wr_bank  out  1  target bank for the write
wr_addr  out  AW  linear CHW address in the bank
wr_data  out  DATA_WIDTH  converted pixel, signed
frame_valid  out  1  a filled bank is available to the consumer
rd_bank  out  1  bank the consumer must read
frame_done  in  1  one-cycle pulse: consumer is finished with rd_bank
loading  out  1  high in LOAD state
drop_cnt  out  CNT_W  frames dropped because both banks were full (saturating)
timeout_cnt  out  CNT_W  frames aborted by timeout (saturating)

Behaviour:
- Reset: state IDLE. wr_ptr=0, rd_ptr=0, full[1:0]=0, addr=0, gap counter=0. All outputs 0: wr_en, wr_bank, wr_addr, wr_data, frame_valid, rd_bank, loading, drop_cnt, timeout_cnt. A reset mid-frame discards the partial frame and both bank contents (full flags cleared).
- Conversion: wr_data = round(k·2^FRAC_BITS/255) = (k·2^FRAC_BITS+127)/255, zero-extended into DATA_WIDTH.
  - Implemented as a 256-entry ROM built at elaboration.
  - Requires DATA_WIDTH > FRAC_BITS+1, so results are always non-negative.
- States:
  - IDLE: rx_dv with rx_byte==SYNC_BYTE:
    - if full[wr_ptr]=0 → LOAD, addr=0.
    - else → DROP, count=0.
    - Non-sync bytes are ignored.
  - LOAD: on each rx_dv:
    - registered write next cycle: wr_en=1, wr_bank=wr_ptr, wr_addr=addr, wr_data=LUT[rx_byte].
    - addr++.
    - on byte FRAME-1: return to IDLE.
    - The SYNC_BYTE value is treated as pixel data inside LOAD.
  - DROP: count rx_dv bytes. After FRAME bytes → IDLE and drop_cnt++ (saturate at 2^CNT_W−1). No writes occur.
- Frame completion:
  - In the cycle the last write is presented (wr_en=1, addr FRAME-1), the flag is set: full[wr_ptr]←1 and wr_ptr toggles.
  - Both take effect the following cycle, so frame_valid rises 1 cycle after the last wr_en.
- Consumer side:
  - frame_valid = full[rd_ptr]; rd_bank = rd_ptr.
  - frame_done while frame_valid: full[rd_ptr]←0, rd_ptr toggles.
  - frame_done while !frame_valid is ignored.
- Simultaneous frame completion and frame_done on the same cycle: both updates apply. They touch different banks by construction.
- Timeout: applies in LOAD and DROP.
  - The gap counter resets on every rx_dv and increments otherwise.
  - On reaching TIMEOUT_CYCLES: return to IDLE, timeout_cnt++ (saturating), addr=0.
  - The partial bank is not marked full; wr_ptr is unchanged.
  - If TIMEOUT_CYCLES=0 the counter is inactive.
- wr_en is a single-cycle pulse per accepted byte. Latency is 1 cycle from rx_dv.
- Bank ordering is FIFO: rd_ptr always points to the oldest full bank.
- loading is combinational from state==LOAD.

Test Plan:
1. IMG_H=IMG_W=4, CHANNELS=2 (FRAME=32). Send A5 then bytes 0,1,128,255,… → wr_data 0,1,64,128. wr_addr runs 0..31 on bank 0. frame_valid rises 1 cycle after wr_addr=31 with rd_bank=0.
2. Two back-to-back frames, no frame_done → second frame lands on bank 1, full=2'b11, frame_valid=1, rd_bank=0. frame_done → rd_bank=1, frame_valid stays 1.
3. Third frame while both banks are full → no wr_en for 32 bytes, drop_cnt=1, state back to IDLE. The next sync after a frame_done loads normally.
4. TIMEOUT_CYCLES=50, stall 60 cycles after byte 10 → timeout_cnt=1, frame_valid unchanged. A fresh A5+32 bytes refills the same bank from addr 0.
5. Garbage bytes 00,FF,12 before A5 → no writes. Inside a frame, a pixel byte equal to A5 → written as LUT[0xA5]=83.
6. Reset asserted at byte 20 of a frame, plus frame_done coincident with frame completion on a second run → all outputs 0 after reset. In the coincident case full updates correctly (one set, one cleared).
